// File: rtl/exec_pkg.sv
// Shared types for the accumulator execution unit: opcodes, sequencer states
// and the predicate that marks opcodes carrying an operand byte.
package exec_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OPC_W  = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP   = 4'h0,
    OP_LDI   = 4'h1,
    OP_LD    = 4'h2,
    OP_ST    = 4'h3,
    OP_ADD   = 4'h4,
    OP_SUB   = 4'h5,
    OP_AND   = 4'h6,
    OP_OR    = 4'h7,
    OP_XOR   = 4'h8,
    OP_MOV   = 4'h9,
    OP_JMP   = 4'hA,
    OP_JZ    = 4'hB,
    OP_JC    = 4'hC,
    OP_UND_D = 4'hD,
    OP_UND_E = 4'hE,
    OP_HLT   = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_DECODE  = 3'd0,
    ST_OPERAND = 3'd1,
    ST_MEM     = 3'd2,
    ST_BRANCH  = 3'd3,
    ST_HALT    = 3'd4
  } state_e;

  function automatic logic is_two_byte(input opcode_e op);
    case (op)
      OP_LDI, OP_LD, OP_ST, OP_JMP, OP_JZ, OP_JC: is_two_byte = 1'b1;
      default:                                    is_two_byte = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU: ADD/SUB produce carry/borrow from a 9-bit result,
// logic ops clear carry; any other opcode passes A through.
module exec_alu
  import exec_pkg::*;
(
  input  opcode_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              c,
  output logic              z
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide = {1'b0, a};
    case (op)
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_XOR:  wide = {1'b0, a ^ b};
      default: wide = {1'b0, a};
    endcase
    result = wide[DATA_W-1:0];
    c      = wide[DATA_W];
    z      = (wide[DATA_W-1:0] == DATA_W'(0));
  end

endmodule

// File: rtl/exec_unit.sv
// Byte-serial accumulator execution unit: decodes one- and two-byte
// instructions, sequences data-memory accesses and issues branch pulses.
module exec_unit
  import exec_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] instr,
  output logic              instr_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target,
  output logic [DATA_W-1:0] acc_out,
  output logic [DATA_W-1:0] b_out,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted,
  output logic              illegal
);

  state_e            state_q, state_d;
  opcode_e           opc_q, opc_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              z_q, z_d;
  logic              c_q, c_d;
  logic              illegal_q, illegal_d;

  opcode_e           dec_op;
  logic              accept;
  logic [DATA_W-1:0] alu_result;
  logic              alu_c;
  logic              alu_z;

  assign dec_op = opcode_e'(instr[DATA_W-1:DATA_W-OPC_W]);
  assign accept = instr_valid && instr_ready;

  exec_alu u_alu (
    .op     (dec_op),
    .a      (acc_q),
    .b      (b_q),
    .result (alu_result),
    .c      (alu_c),
    .z      (alu_z)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_DECODE;
      opc_q     <= OP_NOP;
      addr_q    <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      addr_q    <= addr_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      z_q       <= z_d;
      c_q       <= c_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and architectural update logic.
  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    addr_d    = addr_q;
    acc_d     = acc_q;
    b_d       = b_q;
    z_d       = z_q;
    c_d       = c_q;
    illegal_d = 1'b0;

    case (state_q)
      ST_DECODE: begin
        if (accept) begin
          if (is_two_byte(dec_op)) begin
            opc_d   = dec_op;
            state_d = ST_OPERAND;
          end else begin
            case (dec_op)
              OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                acc_d = alu_result;
                z_d   = alu_z;
                c_d   = alu_c;
              end
              OP_MOV:             b_d       = acc_q;
              OP_HLT:             state_d   = ST_HALT;
              OP_UND_D, OP_UND_E: illegal_d = 1'b1;
              default:            ;
            endcase
          end
        end
      end

      ST_OPERAND: begin
        if (accept) begin
          state_d = ST_DECODE;
          case (opc_q)
            OP_LDI: begin
              acc_d = instr;
              z_d   = (instr == DATA_W'(0));
            end
            OP_LD, OP_ST: begin
              addr_d  = instr;
              state_d = ST_MEM;
            end
            OP_JMP: begin
              addr_d  = instr;
              state_d = ST_BRANCH;
            end
            OP_JZ: begin
              if (z_q) begin
                addr_d  = instr;
                state_d = ST_BRANCH;
              end
            end
            OP_JC: begin
              if (c_q) begin
                addr_d  = instr;
                state_d = ST_BRANCH;
              end
            end
            default: ;
          endcase
        end
      end

      ST_MEM: begin
        if (mem_ack) begin
          if (opc_q == OP_LD) begin
            acc_d = mem_rdata;
            z_d   = (mem_rdata == DATA_W'(0));
          end
          state_d = ST_DECODE;
        end
      end

      ST_BRANCH: state_d = ST_DECODE;

      ST_HALT:   state_d = ST_HALT;

      default:   state_d = ST_DECODE;
    endcase
  end

  // Handshake and status outputs are pure decodes of registered state.
  assign instr_ready = (state_q == ST_DECODE) || (state_q == ST_OPERAND);
  assign mem_req     = (state_q == ST_MEM);
  assign mem_we      = mem_req && (opc_q == OP_ST);
  assign mem_addr    = addr_q;
  assign mem_wdata   = acc_q;
  assign br_taken    = (state_q == ST_BRANCH);
  assign br_target   = addr_q;
  assign acc_out     = acc_q;
  assign b_out       = b_q;
  assign flag_z      = z_q;
  assign flag_c      = c_q;
  assign halted      = (state_q == ST_HALT);
  assign illegal     = illegal_q;

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 CLK  input  1  clock; all state updates on rising edge.
REQ-002 RST  input  1  reset, asynchronous, active-low.
REQ-003 instr_valid  input  1  fetch stage presents an instruction byte.
REQ-004 instr  input  8  instruction byte: opcode [7:4], or full operand byte in second position.
REQ-005 instr_ready  output  1  block accepts a byte; a transfer occurs on a rising edge when instr_valid && instr_ready.
REQ-006 mem_req  output  1  data memory request, held until acknowledged.
REQ-007 mem_we  output  1  1 = store, 0 = load; valid while mem_req.
REQ-008 mem_addr  output  8  data address; valid while mem_req.
REQ-009 mem_wdata  output  8  store data (= A); valid while mem_req && mem_we.
REQ-010 mem_rdata  input  8  load data; sampled on the edge where mem_ack is high.
REQ-011 mem_ack  input  1  completes the current request; may be high in the first request cycle.
REQ-012 br_taken  output  1  one-cycle pulse: fetch reloads pc and discards bytes in flight.
REQ-013 br_target  output  8  new pc; valid while br_taken.
REQ-014 acc_out, b_out  output  8 each  architectural registers A and B.
REQ-015 flag_z, flag_c  output  1 each  zero and carry/borrow flags.
REQ-016 halted  output  1  high after HLT until reset.
REQ-017 illegal  output  1  one-cycle pulse on acceptance of an undefined opcode.

Function
REQ-018 Opcodes SHALL be: 0 NOP; 1 LDI imm; 2 LD addr; 3 ST addr; 4 ADD (A+B); 5 SUB (A-B); 6 AND; 7 OR; 8 XOR; 9 MOV (B<=A); A JMP addr; B JZ addr; C JC addr; F HLT; D,E undefined. Opcodes 1,2,3,A,B,C are two-byte (second byte = imm/addr).
REQ-019 States SHALL be DECODE, OPERAND, MEM, BRANCH, HALT; reset state DECODE.
REQ-020 instr_ready SHALL be high exactly in DECODE and OPERAND.
REQ-021 DECODE, single-byte op accepted: A/B/flags update on that same edge; stay in DECODE (1 byte/cycle throughput).
REQ-022 DECODE, two-byte opcode accepted: latch opcode, go to OPERAND; no architectural change.
REQ-023 OPERAND, byte accepted: LDI -> A<=imm, go DECODE; LD/ST -> latch addr, go MEM with mem_req high next cycle; JMP, JZ with Z=1, JC with C=1 -> go BRANCH; JZ/JC not taken -> go DECODE, no pulse.
REQ-024 MEM: mem_req, mem_we, mem_addr, mem_wdata held stable until mem_ack; on the ack edge LD writes A<=mem_rdata and updates Z; go DECODE.
REQ-025 BRANCH: br_taken=1 and br_target=latched addr for exactly one cycle; then DECODE.
REQ-026 ADD/SUB: 9-bit result, A<=low 8 bits, C<=bit 8 (carry for ADD, borrow for SUB), wrap-around modulo 256.
REQ-027 Z SHALL be set from the new A by LDI, LD, ADD, SUB, AND, OR, XOR; AND/OR/XOR clear C; NOP, MOV, ST, jumps leave flags unchanged.
REQ-028 Undefined opcode: illegal pulses one cycle, otherwise treated as NOP.
REQ-029 HLT: go HALT, halted=1, instr_ready=0 until reset; instr_valid ignored.
REQ-030 Bytes presented while instr_ready=0 SHALL NOT be consumed; fetch holds them.

Reset
REQ-031 RST low SHALL immediately force state DECODE, A=B=0, Z=C=0, mem_req=0, br_taken=0, halted=0, illegal=0, mem_addr=mem_wdata=br_target=0, regardless of an outstanding memory request or pending operand byte.
REQ-032 After RST release, the first accepted byte SHALL be decoded as an opcode.

Structure
REQ-033 Package exec_pkg SHALL hold the opcode enum, the state enum and the two-byte-opcode predicate.
REQ-034 ALU SHALL be a combinational sub-module exec_alu (op, a, b -> result, c, z); sequencing stays in exec_unit.

Verification
REQ-035 LDI 0x7F, MOV, LDI 0x81, ADD -> A=0x00, Z=1, C=1, B=0x7F.
REQ-036 LDI 0x05, MOV, LDI 0x03, SUB -> A=0xFE, C=1, Z=0.
REQ-037 LDI 0x00, JZ 0x40 -> br_taken pulse 1 cycle, br_target=0x40, instr_ready low that cycle; JC 0x40 with C=0 -> no pulse.
REQ-038 ST 0x10 with A=0x5A, mem_ack delayed 3 cycles -> mem_req/mem_we/addr 0x10/wdata 0x5A stable 4 cycles; LD 0x10 with rdata 0x5A, ack same cycle -> A=0x5A.
REQ-039 RST asserted while in MEM and again while in OPERAND -> all outputs zero immediately; next byte 0x10 then 0x22 decoded as LDI giving A=0x22.
REQ-040 Byte 0xD0 -> illegal pulse, registers unchanged; 0xF0 -> halted=1, instr_ready=0, later bytes ignored.
